// File: rtl/dc_ipu_mul_pkg.sv
// Shared types and helpers for the IPU multiplier accumulator stage.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package dc_ipu_mul_pkg;

  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } acc_state_t;

  // Accumulator width: product width plus growth for TAPS additions plus one
  // guard bit, so a full kernel sum can never wrap.
  function automatic int acc_width(input int in_w, input int taps);
    return in_w + $clog2(taps) + 1;
  endfunction

endpackage

// File: rtl/dc_ipu_mul_unit_round_sat.sv
// Rounds a signed kernel sum by FRAC_BITS (half rounds up) and clamps to unsigned pixel range.
// Latency: purely combinational.
// Backpressure: n/a.
// Ports: sum (signed ACC_WIDTH) in; result (OUT_WIDTH) and sat (clamp happened) out.
module dc_ipu_mul_unit_round_sat #(
  parameter int ACC_WIDTH = 23,
  parameter int FRAC_BITS = 6,
  parameter int OUT_WIDTH = 8
) (
  input  logic signed [ACC_WIDTH-1:0] sum,
  output logic        [OUT_WIDTH-1:0] result,
  output logic                        sat
);

  // One extra bit so adding the rounding constant cannot overflow.
  localparam int RW      = ACC_WIDTH + 1;
  localparam int HALF_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
  localparam logic signed [RW-1:0] HALF = (FRAC_BITS > 0) ? RW'(64'sd1 <<< HALF_SH) : '0;
  localparam logic signed [RW-1:0] MAXV = RW'((64'sd1 <<< OUT_WIDTH) - 64'sd1);

  logic signed [RW-1:0] sum_x;
  logic signed [RW-1:0] rnd;

  always_comb begin
    sum_x  = {sum[ACC_WIDTH-1], sum};
    rnd    = (sum_x + HALF) >>> FRAC_BITS;
    result = rnd[OUT_WIDTH-1:0];
    sat    = 1'b0;
    if (rnd[RW-1]) begin
      result = '0;
      sat    = 1'b1;
    end else if (rnd > MAXV) begin
      result = '1;
      sat    = 1'b1;
    end
  end

endmodule

// File: rtl/dc_ipu_mul_unit_accumulator.sv
// Sums TAPS signed products per output sample, rounds and clamps to an unsigned pixel.
// Latency: final tap accepted in cycle N -> out_valid in cycle N+1; one product per cycle.
// Backpressure: while a result waits, in_ready follows out_ready; clr forces in_ready low.
// Ports: clk, reset (async high), clr; in_valid/in_ready/value (signed product);
//        out_valid/out_ready/result/sat (sat qualified by out_valid).
module dc_ipu_mul_unit_accumulator
  import dc_ipu_mul_pkg::*;
#(
  parameter int IN_WIDTH  = 20,
  parameter int TAPS      = 4,
  parameter int FRAC_BITS = 6,
  parameter int OUT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [IN_WIDTH-1:0] value,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic       [OUT_WIDTH-1:0] result,
  output logic                       sat
);

  localparam int ACC_WIDTH = acc_width(IN_WIDTH, TAPS);
  localparam int CNT_WIDTH = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TAPS - 1);

  acc_state_t                   state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic        [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic        [OUT_WIDTH-1:0]  result_q, result_d;
  logic                         sat_q, sat_d;

  logic signed [ACC_WIDTH-1:0]  value_x;
  logic signed [ACC_WIDTH-1:0]  sum;
  logic        [OUT_WIDTH-1:0]  rs_result;
  logic                         rs_sat;

  assign value_x = {{(ACC_WIDTH-IN_WIDTH){value[IN_WIDTH-1]}}, value};
  // acc_q is zero whenever a beat starts a new sample, so this sum serves
  // both the final-tap and the TAPS==1 reload paths.
  assign sum     = acc_q + value_x;

  dc_ipu_mul_unit_round_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_round_sat (
    .sum    (sum),
    .result (rs_result),
    .sat    (rs_sat)
  );

  // Depends only on state, clr and out_ready, never on in_valid.
  assign in_ready  = !clr && ((state_q == S_ACC) || out_ready);
  assign out_valid = (state_q == S_OUT);
  assign result    = result_q;
  assign sat       = sat_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    sat_d    = sat_q;
    if (clr) begin
      // Flush partial sum and pending output; result/sat keep last value.
      state_d = S_ACC;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_ACC: begin
          if (in_valid) begin
            if (cnt_q != CNT_LAST) begin
              acc_d = sum;
              cnt_d = cnt_q + CNT_WIDTH'(1);
            end else begin
              result_d = rs_result;
              sat_d    = rs_sat;
              acc_d    = '0;
              cnt_d    = '0;
              state_d  = S_OUT;
            end
          end
        end
        S_OUT: begin
          if (out_ready) begin
            if (!in_valid) begin
              state_d = S_ACC;
            end else if (TAPS == 1) begin
              result_d = rs_result;
              sat_d    = rs_sat;
            end else begin
              // Beat taken in the same cycle the result leaves is tap 0.
              acc_d   = value_x;
              cnt_d   = CNT_WIDTH'(1);
              state_d = S_ACC;
            end
          end
        end
        default: state_d = S_ACC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_ACC;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      sat_q    <= sat_d;
    end
  end

endmodule

// File: tb/tb_dc_ipu_mul_unit_accumulator.sv
// Directed bench for the accumulator with a scoreboard of expected pixels.
// Latency: n/a.
// Backpressure: exercised by stalling out_ready.
module tb_dc_ipu_mul_unit_accumulator;

  logic               clk;
  logic               reset;
  logic               clr;
  logic               in_valid;
  logic               in_ready;
  logic signed [19:0] value;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         result;
  logic               sat;

  int checks = 0;
  int passes = 0;

  logic [8:0] exp_q[$];
  longint     m_acc = 0;
  int         m_cnt = 0;

  dc_ipu_mul_unit_accumulator #(
    .IN_WIDTH  (20),
    .TAPS      (4),
    .FRAC_BITS (6),
    .OUT_WIDTH (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .value     (value),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .sat       (sat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: round half up by 6 fraction bits, clamp to 0..255.
  function automatic logic [8:0] model(input longint s);
    longint r;
    r = (s + 64'sd32) >>> 6;
    if (r < 0)   return {1'b1, 8'd0};
    if (r > 255) return {1'b1, 8'd255};
    return {1'b0, r[7:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Scoreboard: compare every result the downstream side actually takes.
  always @(negedge clk) begin
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("sb_result", {24'd0, result}, {24'd0, e[7:0]});
        check("sb_sat", {31'd0, sat}, {31'd0, e[8]});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input logic signed [19:0] v);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    value    = v;
    @(negedge clk);
    while (in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      check("send_timeout_in_ready", {31'd0, in_ready}, 32'd1);
    end else begin
      @(posedge clk);
      #1;
      m_acc += v;
      m_cnt++;
      if (m_cnt == 4) begin
        exp_q.push_back(model(m_acc));
        m_acc = 0;
        m_cnt = 0;
      end
    end
  endtask

  task automatic send4(input logic signed [19:0] a, input logic signed [19:0] b,
                       input logic signed [19:0] c, input logic signed [19:0] d);
    send(a);
    send(b);
    send(c);
    send(d);
    in_valid = 1'b0;
  endtask

  task automatic sample(input string tag, input logic [7:0] r, input logic s);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_result"}, {24'd0, result}, {24'd0, r});
    check({tag, "_sat"}, {31'd0, sat}, {31'd0, s});
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    clr       = 1'b0;
    in_valid  = 1'b0;
    value     = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_result", {24'd0, result}, 32'd0);
    check("rst_sat", {31'd0, sat}, 32'd0);
    @(posedge clk);
    #1;

    // Basic sum: one out_valid cycle right after the 4th accept.
    send4(64, 64, 64, 64);
    sample("basic", 8'd4, 1'b0);
    idle();
    check("basic_single_cycle", {31'd0, out_valid}, 32'd0);

    // Rounding and clamping.
    send4(32, 0, 0, 0);
    sample("round_half", 8'd1, 1'b0);
    send4(31, 0, 0, 0);
    sample("round_below", 8'd0, 1'b0);
    send4(16384, 16384, 16384, 16384);
    sample("clamp_hi", 8'd255, 1'b1);
    send4(-100, 0, 0, 0);
    sample("clamp_lo", 8'd0, 1'b1);
    idle();

    // Backpressure: result held for 10 cycles, next beat waits, nothing lost.
    out_ready = 1'b0;
    send4(100, 200, 300, 400);
    sample("bp_first", 8'd16, 1'b0);
    in_valid = 1'b1;
    value    = -50;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_held", {24'd0, result}, {24'd0, exp_q[0][7:0]});
      @(posedge clk);
      #1;
    end
    check("bp_still_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    send4(-50, 5000, 70, 3);
    sample("bp_second", 8'd78, 1'b0);
    idle();

    // clr drops a partial sum and the beat presented with it.
    send(1000);
    send(1000);
    in_valid = 1'b1;
    value    = 999;
    clr      = 1'b1;
    @(negedge clk);
    check("clr_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    clr   = 1'b0;
    m_acc = 0;
    m_cnt = 0;
    send4(128, 128, 128, 128);
    sample("after_clr", 8'd8, 1'b0);
    idle();

    // clr while a result is pending.
    out_ready = 1'b0;
    send4(64, 64, 64, 64);
    sample("clr_pending", 8'd4, 1'b0);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    void'(exp_q.pop_front());
    check("clr_out_valid_drop", {31'd0, out_valid}, 32'd0);
    check("clr_result_kept", {24'd0, result}, 32'd4);
    out_ready = 1'b1;
    idle();
    check("clr_out_valid_stays", {31'd0, out_valid}, 32'd0);

    // Async reset mid-sample, off the clock edge.
    send(500);
    send(500);
    in_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    m_acc = 0;
    m_cnt = 0;
    @(negedge clk);
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    send4(64, 64, 64, 64);
    sample("post_rst", 8'd4, 1'b0);
    repeat (4) idle();
    check("sb_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
